// File: rtl/poly1305_pkg.sv
// poly1305_pkg: shared Poly1305 widths, prime, r clamp mask, sequencer states and block padding helper
package poly1305_pkg;
  localparam int ACC_W = 130;
  localparam int KEY_W = 128;
  localparam int PROD_W = 258;
  localparam logic [ACC_W-1:0] P = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [KEY_W-1:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  typedef enum logic [2:0] {IDLE, WAIT_BLK, MUL, RED, FINAL} state_t;
  function automatic logic [KEY_W:0] pad_block(input logic [KEY_W-1:0] data, input logic [4:0] len);
    logic [KEY_W:0] one;
    one = (KEY_W + 1)'(1) << {len, 3'b000};
    return ({1'b0, data} & (one - (KEY_W + 1)'(1))) | one;
  endfunction
endpackage

// File: rtl/poly1305_finalize.sv
// poly1305_finalize: final subtract of P from acc then add s mod 2^128 (in: acc, s; out: tag)
module poly1305_finalize
  import poly1305_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [KEY_W-1:0] s,
  output logic [KEY_W-1:0] tag
);
  assign tag = KEY_W'((acc >= P ? acc - P : acc) + {2'b00, s});
endmodule

// File: rtl/poly1305_mac_sequencer.sv
// poly1305_mac_sequencer: Poly1305 MAC sequencer (key load, block handshake, external mul/red control, tag/busy/err outputs)
module poly1305_mac_sequencer
  import poly1305_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  r_in,
  input  logic [KEY_W-1:0]  s_in,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [KEY_W-1:0]  blk_data,
  input  logic [4:0]        blk_len,
  input  logic              blk_last,
  output logic              mul_start,
  output logic [ACC_W-1:0]  mul_a,
  output logic [KEY_W-1:0]  mul_b,
  input  logic [PROD_W-1:0] mul_product,
  input  logic              mul_done,
  output logic              red_start,
  output logic [PROD_W-1:0] red_in,
  input  logic [ACC_W-1:0]  red_out,
  input  logic              red_done,
  output logic              tag_valid,
  output logic [KEY_W-1:0]  tag,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_next;
  logic [KEY_W-1:0] r, s, tag_final;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic [CW-1:0] cnt;
  logic last, accept, len_bad, abort;
  assign mul_b = r;
  poly1305_finalize u_finalize (.acc(acc), .s(s), .tag(tag_final));
  always_comb begin
    blk_ready = state == WAIT_BLK && !key_load;
    busy = state inside {MUL, RED, FINAL};
    accept = blk_valid && blk_ready;
    len_bad = blk_len == 5'd0 || blk_len > 5'd16;
    sum = {1'b0, acc} + {2'b00, pad_block(blk_data, blk_len)};
    abort = cnt == CW'(TIMEOUT - 1) && ((state == MUL && !mul_done) || (state == RED && !red_done));
    state_next = state;
    case (state)
      IDLE:     state_next = key_load ? WAIT_BLK : IDLE;
      WAIT_BLK: state_next = key_load ? WAIT_BLK : accept ? (len_bad ? IDLE : MUL) : WAIT_BLK;
      MUL:      state_next = mul_done ? RED : abort ? IDLE : MUL;
      RED:      state_next = red_done ? (last ? FINAL : WAIT_BLK) : abort ? IDLE : RED;
      FINAL:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r <= '0;
      s <= '0;
      acc <= '0;
      last <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
      tag <= '0;
      tag_valid <= 1'b0;
      mul_start <= 1'b0;
      red_start <= 1'b0;
      mul_a <= '0;
      red_in <= '0;
    end else begin
      state <= state_next;
      cnt <= cnt + CW'(1);
      mul_start <= 1'b0;
      red_start <= 1'b0;
      tag_valid <= 1'b0;
      if (key_load && (state == IDLE || state == WAIT_BLK)) begin
        r <= r_in & CLAMP;
        s <= s_in;
        acc <= '0;
        err <= 1'b0;
        tag <= '0;
      end
      if (accept && len_bad) err <= 1'b1;
      // 2^130 == 5 mod P, so the carry bit of the sum folds back in as +5
      if (accept && !len_bad) begin
        mul_a <= sum[ACC_W-1:0] + (sum[ACC_W] ? ACC_W'(5) : '0);
        last <= blk_last;
        mul_start <= 1'b1;
        cnt <= '0;
      end
      if (state == MUL && mul_done) begin
        red_in <= mul_product;
        red_start <= 1'b1;
        cnt <= '0;
      end
      if (state == RED && red_done) acc <= red_out;
      if (abort) err <= 1'b1;
      if (state == FINAL) begin
        tag <= tag_final;
        tag_valid <= 1'b1;
      end
    end
  end
endmodule
